// File: rtl/bip_pkg.sv
// bip_pkg: shared opcodes, FSM states, select encodings and control bundle for the BIP control unit.
package bip_pkg;
  localparam int NBITS_O = 11;
  localparam int NBITS_D = 16;
  localparam int NBITS_OPC = 5;
  localparam logic [NBITS_OPC-1:0] OPC_HLT = 5'd0;
  localparam logic [NBITS_OPC-1:0] OPC_STO = 5'd1;
  localparam logic [NBITS_OPC-1:0] OPC_LD = 5'd2;
  localparam logic [NBITS_OPC-1:0] OPC_LDI = 5'd3;
  localparam logic [NBITS_OPC-1:0] OPC_ADD = 5'd4;
  localparam logic [NBITS_OPC-1:0] OPC_ADDI = 5'd5;
  localparam logic [NBITS_OPC-1:0] OPC_SUB = 5'd6;
  localparam logic [NBITS_OPC-1:0] OPC_SUBI = 5'd7;
  localparam logic [1:0] SELA_RAM = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_e;
  typedef struct packed {
    logic rd_ram;
    logic wr_ram;
    logic wr_acc;
    logic [1:0] sel_a;
    logic sel_b;
    logic op;
  } ctrl_t;
endpackage

// File: rtl/bip_if.sv
// bip_if: program-memory / datapath bus of the BIP control unit; o_cycle_count exists only with BIP_CYCLE_COUNT_EN.
interface bip_if #(parameter int NBITS_O = 11, parameter int NBITS_D = 16);
  logic i_enable;
  logic [NBITS_D-1:0] i_instr;
  logic [NBITS_O-1:0] o_pc;
  logic [NBITS_O-1:0] o_operand;
  logic [1:0] o_sel_a;
  logic o_sel_b;
  logic o_op;
  logic o_rd_ram;
  logic o_wr_ram;
  logic o_wr_acc;
  logic o_halt;
`ifdef BIP_CYCLE_COUNT_EN
  logic [31:0] o_cycle_count;
`endif
  modport master (
    input i_enable, i_instr,
    output o_pc, o_operand, o_sel_a, o_sel_b, o_op, o_rd_ram, o_wr_ram, o_wr_acc, o_halt
`ifdef BIP_CYCLE_COUNT_EN
    , output o_cycle_count
`endif
  );
  modport slave (
    output i_enable, i_instr,
    input o_pc, o_operand, o_sel_a, o_sel_b, o_op, o_rd_ram, o_wr_ram, o_wr_acc, o_halt
`ifdef BIP_CYCLE_COUNT_EN
    , input o_cycle_count
`endif
  );
endinterface

// File: rtl/bip_decoder.sv
// bip_decoder: purely combinational opcode to strobe/select bundle.
module bip_decoder
  import bip_pkg::*;
(
  input  logic [NBITS_OPC-1:0] opc_i,
  output ctrl_t                ctrl_o
);
  logic alu;
  assign alu = opc_i inside {OPC_ADD, OPC_ADDI, OPC_SUB, OPC_SUBI};
  assign ctrl_o.rd_ram = opc_i inside {OPC_LD, OPC_ADD, OPC_SUB};
  assign ctrl_o.wr_ram = opc_i == OPC_STO;
  assign ctrl_o.wr_acc = alu || opc_i inside {OPC_LD, OPC_LDI};
  assign ctrl_o.sel_a = alu ? SELA_ALU : opc_i == OPC_LDI ? SELA_IMM : SELA_RAM;
  assign ctrl_o.sel_b = opc_i inside {OPC_ADDI, OPC_SUBI};
  assign ctrl_o.op = opc_i inside {OPC_SUB, OPC_SUBI} ? OP_SUB : OP_ADD;
endmodule

// File: rtl/bip_control.sv
// bip_control: FETCH/DECODE/EXEC sequencer of the accumulator CPU; optional BIP_CYCLE_COUNT_EN adds a run-time counter.
module bip_control
  import bip_pkg::*;
#(
  parameter int NBITS_O = 11,
  parameter int NBITS_D = 16,
  parameter int NBITS_OPC = 5
) (
  input logic i_clk,
  input logic i_reset,
  bip_if.master bus
);
  state_e state_q, state_d;
  logic [NBITS_O-1:0] pc_q, pc_d;
  logic [NBITS_D-1:0] ir_q, ir_d;
  logic [NBITS_OPC-1:0] opc;
  logic en, exec_s;
  ctrl_t ctrl;
  assign en = bus.i_enable;
  assign exec_s = state_q == EXEC;
  // DECODE decodes the live instruction (for rd_ram), EXEC the latched one
  assign opc = state_q == DECODE ? bus.i_instr[NBITS_D-1 -: NBITS_OPC] : ir_q[NBITS_D-1 -: NBITS_OPC];
  bip_decoder u_dec (.opc_i(opc), .ctrl_o(ctrl));
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    if (en && state_q == FETCH) state_d = DECODE;
    if (en && state_q == DECODE) begin
      ir_d = bus.i_instr;
      state_d = opc == OPC_HLT ? HALT : EXEC;
    end
    if (en && exec_s) begin
      pc_d = pc_q + 1'b1;
      state_d = FETCH;
    end
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= FETCH;
      pc_q <= '0;
      ir_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end
  assign bus.o_pc = pc_q;
  assign bus.o_operand = ir_q[NBITS_O-1:0];
  assign bus.o_halt = state_q == HALT;
  assign bus.o_rd_ram = en && state_q == DECODE && ctrl.rd_ram;
  assign bus.o_wr_ram = en && exec_s && ctrl.wr_ram;
  assign bus.o_wr_acc = en && exec_s && ctrl.wr_acc;
  assign bus.o_sel_a = exec_s ? ctrl.sel_a : SELA_RAM;
  assign bus.o_sel_b = exec_s && ctrl.sel_b;
  assign bus.o_op = exec_s ? ctrl.op : OP_ADD;
`ifdef BIP_CYCLE_COUNT_EN
  logic [31:0] cnt_q, cnt_d;
  assign cnt_d = (en && state_q != HALT && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign bus.o_cycle_count = cnt_q;
`endif
endmodule

// File: doc/bip_control.md
Name: bip_control

Overview:
- Fetch/decode/sequencing unit for the accumulator CPU; sits directly upstream of the program memory.
- Drives the instruction address, receives the 16-bit instruction one clock later (the program memory read is synchronous, 1-cycle latency), and decodes it.
- Drives the data-RAM and accumulator/ALU control strobes to the datapath.
- Three-cycle FETCH/DECODE/EXEC sequence per instruction; stops permanently on HALT until reset.

Parameters:
- NBITS_O, 11, operand/address width (instruction bits [10:0]).
- NBITS_D, 16, instruction width.
- NBITS_OPC, 5, opcode width (instruction bits [15:11]); NBITS_OPC+NBITS_O must equal NBITS_D.

Ports:
- i_clk  in  1  system clock, all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  run enable; low freezes all state.
- i_instr  in  NBITS_D  instruction from program memory, valid the cycle after o_pc is presented.
- o_pc  out  NBITS_O  program counter, drives program memory i_Addr.
- o_operand  out  NBITS_O  latched operand: data-RAM address or immediate.
- o_sel_a  out  2  accumulator input mux: 00 RAM data, 01 immediate, 10 ALU result.
- o_sel_b  out  1  ALU B operand: 0 RAM data, 1 immediate.
- o_op  out  1  ALU op: 0 add, 1 subtract.
- o_rd_ram  out  1  data-RAM read strobe.
- o_wr_ram  out  1  data-RAM write strobe (stores accumulator).
- o_wr_acc  out  1  accumulator load strobe.
- o_halt  out  1  processor halted.

Behaviour:
- Reset (async, any state):
  - State FETCH, pc=0, instruction latch=0, o_operand=0, o_halt=0.
  - All strobes 0; o_sel_a=00, o_sel_b=0, o_op=0.
- FETCH:
  - o_pc=pc presented; no strobes.
  - Next state DECODE. i_instr is ignored in this cycle; it may hold a stale or default value.
- DECODE:
  - Latch i_instr into the instruction register; o_operand = i_instr[10:0], registered.
  - o_rd_ram=1 in this cycle for LD, ADD, SUB (address = i_instr[10:0]), driven combinationally.
  - Opcode 00000 (HLT): next state HALT. Otherwise next state EXEC.
- EXEC: decode comes from the latched instruction. Datapath samples strobes at the closing edge.
  - 00001 STO: o_wr_ram=1.
  - 00010 LD: o_wr_acc=1, sel_a=00.
  - 00011 LDI: o_wr_acc=1, sel_a=01.
  - 00100 ADD: wr_acc, sel_a=10, sel_b=0, op=0.
  - 00101 ADDI: wr_acc, sel_a=10, sel_b=1, op=0.
  - 00110 SUB: wr_acc, sel_a=10, sel_b=0, op=1.
  - 00111 SUBI: wr_acc, sel_a=10, sel_b=1, op=1.
  - Any other opcode: NOP, no strobes.
  - pc <= pc+1, modulo 2^NBITS_O (wraps 0x7FF -> 0x000); next state FETCH.
- HALT:
  - o_halt=1; pc frozen at the HLT address; all strobes 0.
  - Only exit is reset.
- i_enable=0:
  - State, pc, and latches hold.
  - All strobes forced 0 (no RAM/ACC side effects).
  - Resuming continues in the same state. Because the instruction is latched in DECODE, a stall during EXEC is safe.
  - A stall in DECODE re-samples i_instr on resume; the program memory is clocked every cycle with an unchanged address, so the value is identical.
- Throughput: exactly 3 clocks per non-halt instruction when enabled; HLT is reached 2 clocks after its fetch.
- Strobes are Moore-style (state + latched instruction), except o_rd_ram in DECODE, which is combinational from i_instr.

Optional Feature:
- Macro BIP_CYCLE_COUNT_EN.
- Defined:
  - Adds output o_cycle_count, 32 bits. Reset to 0.
  - Increments each enabled clock while not halted; saturates at 0xFFFFFFFF.
  - Frozen in HALT (total run time for the debug unit).
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package bip_pkg:
  - Opcode localparams (OPC_HLT..OPC_SUBI).
  - State encoding typedef (FETCH, DECODE, EXEC, HALT).
  - sel_a encodings (SELA_RAM, SELA_IMM, SELA_ALU) and op encodings.
- One sub-module: bip_decoder, purely combinational (opcode -> strobe/select bundle).
- The FSM, pc and latches stay in bip_control.

Test Plan:
- Reset, then run the 10-instruction program (LD 1, ADDI 2, STO 7, LDI 8, SUB 2, ADD 3, STO 8, LD 8, SUBI 1, HLT) with program memory modelled:
  - o_pc steps 0..9, 3 clocks apart.
  - o_halt=1 at the 29th cycle after reset release, o_pc stays 9.
  - Golden datapath model gives ACC=0x08, RAM[7]=0x03, RAM[8]=0x09.
- Strobe check on ADDI 0x002:
  - EXEC shows wr_acc=1, sel_a=10, sel_b=1, op=0, o_operand=0x002.
  - DECODE shows rd_ram=0.
- Illegal opcode 0x1F (program memory default 0xF800): no strobes in any cycle; pc increments; no halt.
- Hold i_enable=0 for 5 clocks mid-EXEC of STO: o_wr_ram stays 0 while stalled, pulses exactly once after release; pc advances by 1 only.
- Assert i_reset asynchronously mid-DECODE: outputs go to reset values before the next edge; fetch restarts at pc=0.
- Preload pc wrap: NOP at 0x7FF -> next o_pc=0x000. With BIP_CYCLE_COUNT_EN defined, o_cycle_count freezes at halt.
